// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32 types plus the imem arbiter state and requester enums.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int c_imem_addr_w = 10;
    localparam logic [31:0] c_stat_max = 32'hFFFF_FFFF;

    typedef logic [c_imem_addr_w-1:0] rv32_dmem_addr_t;
    typedef logic [31:0]              rv32_data_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } rv32_imem_arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DBG   = 1'b1
    } rv32_imem_req_id_t;

    function automatic logic [31:0] rv32_sat_inc(input logic [31:0] v);
        return (v == c_stat_max) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rv32_rr_arb2
// Description : Two-way round-robin arbiter; index 0 is favoured after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

    // Set when index 1 owns the next contended cycle.
    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req_valid == 2'b11) begin
                grant = r_ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (en && (req_valid == 2'b11)) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imem_arbiter
// Description : Shares the imem read port between fetch and debug and hands
//               the write port to the program loader during a load session.
//               Optional counters: define RV32_IMEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_imem_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W = $bits(rv32_dmem_addr_t),
    parameter int DATA_W = $bits(rv32_data_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_valid,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_req_ready,
    output logic              fetch_rsp_valid,
    output logic [DATA_W-1:0] fetch_rsp_data,
    input  logic              dbg_req_valid,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    output logic              dbg_req_ready,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_data,
    input  logic              ld_start,
    input  logic              ld_done,
    input  logic              ld_wr_valid,
    input  logic [ADDR_W-1:0] ld_wr_addr,
    input  logic [DATA_W-1:0] ld_wr_data,
    output logic              ld_wr_ready,
    output logic              ld_active,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_rdaddress,
    input  logic [DATA_W-1:0] mem_q
`ifdef RV32_IMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_fetch_grants,
    output logic [31:0]       stat_dbg_grants,
    output logic [31:0]       stat_contention
`endif
);

    rv32_imem_arb_state_t r_state;
    rv32_imem_req_id_t    r_rsp_owner;
    logic                 r_rsp_valid;
    logic [ADDR_W-1:0]    r_rdaddr_hold;

    logic                 w_run;
    logic                 w_load;
    logic                 w_rd_fire;
    logic                 w_ld_accept;
    logic [1:0]           w_req;
    logic [1:0]           w_grant;

    // Reset is folded in so the combinational readies are also 0 while rst is held.
    assign w_run       = (r_state == ST_RUN) && !rst;
    assign w_load      = (r_state == ST_LOAD);
    assign w_req       = {dbg_req_valid, fetch_req_valid};
    assign w_ld_accept = (r_state == ST_RUN) && ld_start;

    rv32_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (w_run),
        .req_valid (w_req),
        .grant     (w_grant)
    );

    assign fetch_req_ready = w_grant[0];
    assign dbg_req_ready   = w_grant[1];
    assign w_rd_fire       = |w_grant;
    assign mem_rdaddress   = w_grant[1] ? dbg_req_addr :
                             w_grant[0] ? fetch_req_addr : r_rdaddr_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   if (w_ld_accept) r_state <= ST_DRAIN;
                ST_DRAIN: r_state <= ST_LOAD;
                ST_LOAD:  if (ld_done) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_owner   <= REQ_FETCH;
            r_rdaddr_hold <= '0;
        end else begin
            r_rsp_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rsp_owner   <= w_grant[1] ? REQ_DBG : REQ_FETCH;
                r_rdaddr_hold <= mem_rdaddress;
            end
        end
    end

    assign fetch_rsp_valid = r_rsp_valid && (r_rsp_owner == REQ_FETCH);
    assign dbg_rsp_valid   = r_rsp_valid && (r_rsp_owner == REQ_DBG);
    assign fetch_rsp_data  = fetch_rsp_valid ? mem_q : '0;
    assign dbg_rsp_data    = dbg_rsp_valid   ? mem_q : '0;

    assign ld_active     = (r_state != ST_RUN);
    assign ld_wr_ready   = w_load;
    assign mem_wren      = w_load && ld_wr_valid;
    assign mem_wraddress = w_load ? ld_wr_addr : '0;
    assign mem_data      = w_load ? ld_wr_data : '0;

`ifdef RV32_IMEM_ARB_STATS_EN
    logic [31:0] r_stat_fetch;
    logic [31:0] r_stat_dbg;
    logic [31:0] r_stat_cont;

    // A new load session starts the statistics window afresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_fetch <= '0;
            r_stat_dbg   <= '0;
            r_stat_cont  <= '0;
        end else if (w_ld_accept) begin
            r_stat_fetch <= '0;
            r_stat_dbg   <= '0;
            r_stat_cont  <= '0;
        end else begin
            if (w_grant[0]) r_stat_fetch <= rv32_sat_inc(r_stat_fetch);
            if (w_grant[1]) r_stat_dbg   <= rv32_sat_inc(r_stat_dbg);
            if (fetch_req_valid && dbg_req_valid) r_stat_cont <= rv32_sat_inc(r_stat_cont);
        end
    end

    assign stat_fetch_grants = r_stat_fetch;
    assign stat_dbg_grants   = r_stat_dbg;
    assign stat_contention   = r_stat_cont;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_imem_arbiter
// Description : Table-driven and randomized bench for rv32_imem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_imem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req_valid, dbg_req_valid;
    logic [AW-1:0] fetch_req_addr, dbg_req_addr;
    logic          fetch_req_ready, dbg_req_ready;
    logic          fetch_rsp_valid, dbg_rsp_valid;
    logic [DW-1:0] fetch_rsp_data, dbg_rsp_data;
    logic          ld_start, ld_done, ld_wr_valid, ld_wr_ready, ld_active;
    logic [AW-1:0] ld_wr_addr;
    logic [DW-1:0] ld_wr_data;
    logic [AW-1:0] mem_wraddress, mem_rdaddress;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_wren;
`ifdef RV32_IMEM_ARB_STATS_EN
    logic [31:0]   stat_fetch_grants, stat_dbg_grants, stat_contention;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32_imem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_addr  (fetch_req_addr),
        .fetch_req_ready (fetch_req_ready),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_data  (fetch_rsp_data),
        .dbg_req_valid   (dbg_req_valid),
        .dbg_req_addr    (dbg_req_addr),
        .dbg_req_ready   (dbg_req_ready),
        .dbg_rsp_valid   (dbg_rsp_valid),
        .dbg_rsp_data    (dbg_rsp_data),
        .ld_start        (ld_start),
        .ld_done         (ld_done),
        .ld_wr_valid     (ld_wr_valid),
        .ld_wr_addr      (ld_wr_addr),
        .ld_wr_data      (ld_wr_data),
        .ld_wr_ready     (ld_wr_ready),
        .ld_active       (ld_active),
        .mem_wraddress   (mem_wraddress),
        .mem_data        (mem_data),
        .mem_wren        (mem_wren),
        .mem_rdaddress   (mem_rdaddress),
        .mem_q           (mem_q)
`ifdef RV32_IMEM_ARB_STATS_EN
        ,
        .stat_fetch_grants (stat_fetch_grants),
        .stat_dbg_grants   (stat_dbg_grants),
        .stat_contention   (stat_contention)
`endif
    );

    // Instruction memory: registered read, one cycle latency.
    logic [DW-1:0] imem [0:(1<<AW)-1];
    always @(posedge clk) begin
        mem_q <= imem[mem_rdaddress];
        if (mem_wren) imem[mem_wraddress] <= mem_data;
    end

    // Reference model: mode 0 = running, 1 = draining, 2 = loading.
    int            m_mode;
    bit            m_next_dbg;
    logic [DW-1:0] gold [0:(1<<AW)-1];

    typedef struct {
        bit            fv;
        logic [AW-1:0] fa;
        bit            dv;
        logic [AW-1:0] da;
        bit            st;
        bit            dn;
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            use_exp;
        bit            e_f, e_d, e_act, e_wrr, e_wren;
    } vec_t;

    vec_t tbl[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit fv, input int fa, input bit dv, input int da,
                                input bit st, input bit dn, input bit wv, input int wa,
                                input logic [31:0] wd, input bit ef, input bit ed,
                                input bit eact, input bit ewrr, input bit ewren);
        vec_t v;
        v.fv = fv; v.fa = AW'(fa); v.dv = dv; v.da = AW'(da);
        v.st = st; v.dn = dn; v.wv = wv; v.wa = AW'(wa); v.wd = wd;
        v.use_exp = 1'b1;
        v.e_f = ef; v.e_d = ed; v.e_act = eact; v.e_wrr = ewrr; v.e_wren = ewren;
        return v;
    endfunction

    function automatic vec_t stim(input bit fv, input int fa, input bit dv, input int da,
                                  input bit st, input bit dn, input bit wv, input int wa,
                                  input logic [31:0] wd);
        vec_t v;
        v = mk(fv, fa, dv, da, st, dn, wv, wa, wd, 0, 0, 0, 0, 0);
        v.use_exp = 1'b0;
        return v;
    endfunction

    task automatic clear_inputs();
        fetch_req_valid = 0; fetch_req_addr = '0;
        dbg_req_valid   = 0; dbg_req_addr   = '0;
        ld_start = 0; ld_done = 0;
        ld_wr_valid = 0; ld_wr_addr = '0; ld_wr_data = '0;
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_next_dbg = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_fetch_ready"}, fetch_req_ready, 1'b0);
        chk1({tag, "_dbg_ready"},   dbg_req_ready,   1'b0);
        chk1({tag, "_fetch_rsp"},   fetch_rsp_valid, 1'b0);
        chk1({tag, "_dbg_rsp"},     dbg_rsp_valid,   1'b0);
        chk32({tag, "_fetch_data"}, fetch_rsp_data,  32'h0);
        chk32({tag, "_dbg_data"},   dbg_rsp_data,    32'h0);
        chk1({tag, "_wr_ready"},    ld_wr_ready,     1'b0);
        chk1({tag, "_ld_active"},   ld_active,       1'b0);
        chk1({tag, "_mem_wren"},    mem_wren,        1'b0);
        chk32({tag, "_wraddr"},     32'(mem_wraddress), 32'h0);
        chk32({tag, "_wrdata"},     mem_data,        32'h0);
        chk32({tag, "_rdaddr"},     32'(mem_rdaddress), 32'h0);
`ifdef RV32_IMEM_ARB_STATS_EN
        chk32({tag, "_stat_f"}, stat_fetch_grants, 32'h0);
        chk32({tag, "_stat_d"}, stat_dbg_grants,   32'h0);
        chk32({tag, "_stat_c"}, stat_contention,   32'h0);
`endif
    endtask

    // One clock of stimulus, checked against the model and optionally the table row.
    task automatic cycle(input vec_t v);
        bit            ef, ed, ewren, contended;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        fetch_req_valid = v.fv; fetch_req_addr = v.fa;
        dbg_req_valid   = v.dv; dbg_req_addr   = v.da;
        ld_start = v.st; ld_done = v.dn;
        ld_wr_valid = v.wv; ld_wr_addr = v.wa; ld_wr_data = v.wd;

        ef = 0; ed = 0;
        contended = (m_mode == 0) && v.fv && v.dv;
        if (m_mode == 0) begin
            if (contended) begin
                ed = m_next_dbg;
                ef = !m_next_dbg;
            end else begin
                ef = v.fv;
                ed = v.dv;
            end
        end
        ewren = (m_mode == 2) && v.wv;

        #1;
        chk1("fetch_ready", fetch_req_ready, ef);
        chk1("dbg_ready",   dbg_req_ready,   ed);
        chk1("wr_ready",    ld_wr_ready,     m_mode == 2);
        chk1("ld_active",   ld_active,       m_mode != 0);
        chk1("mem_wren",    mem_wren,        ewren);
        if (ef) chk32("rdaddr_fetch", 32'(mem_rdaddress), 32'(v.fa));
        if (ed) chk32("rdaddr_dbg",   32'(mem_rdaddress), 32'(v.da));
        if (ewren) begin
            chk32("wraddr", 32'(mem_wraddress), 32'(v.wa));
            chk32("wrdata", mem_data, v.wd);
        end
        if (v.use_exp) begin
            chk1("tbl_fetch_ready", fetch_req_ready, v.e_f);
            chk1("tbl_dbg_ready",   dbg_req_ready,   v.e_d);
            chk1("tbl_ld_active",   ld_active,       v.e_act);
            chk1("tbl_wr_ready",    ld_wr_ready,     v.e_wrr);
            chk1("tbl_mem_wren",    mem_wren,        v.e_wren);
        end

        @(posedge clk);
        #1;
        exp_data = ef ? gold[v.fa] : (ed ? gold[v.da] : '0);
        if (ewren) gold[v.wa] = v.wd;
        chk1("fetch_rsp_valid", fetch_rsp_valid, ef);
        chk1("dbg_rsp_valid",   dbg_rsp_valid,   ed);
        if (ef) chk32("fetch_rsp_data", fetch_rsp_data, exp_data);
        if (ed) chk32("dbg_rsp_data",   dbg_rsp_data,   exp_data);

        if (contended) m_next_dbg = !ed;
        if (m_mode == 0 && v.st)      m_mode = 1;
        else if (m_mode == 1)         m_mode = 2;
        else if (m_mode == 2 && v.dn) m_mode = 0;
    endtask

    int mark_s3, mark_s4a, mark_s4b;

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        // Preload: 0..3 = NOP, 4..7 distinct; last write coincides with ld_done.
        tbl.push_back(mk(0,0,0,0, 1,0, 0,0,0,       0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,1,0,0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0,0,0,0, 0,(k==7), 1,k, (k<4) ? 32'h0000_0013 : 32'h100 + 32'(k),
                             0,0,1,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,0,0,0));
        // Contention: F, D, F, D.
        tbl.push_back(mk(1,4,1,6, 0,0, 0,0,0,       1,0,0,0,0));
        tbl.push_back(mk(1,5,1,7, 0,0, 0,0,0,       0,1,0,0,0));
        tbl.push_back(mk(1,4,1,6, 0,0, 0,0,0,       1,0,0,0,0));
        tbl.push_back(mk(1,5,1,7, 0,0, 0,0,0,       0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,0,0,0));
        mark_s3 = tbl.size() - 1;
        // Back-to-back fetch of 0..3.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,k,0,0, 0,0, 0,0,0,   1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,0,0,0));
        // ld_start with a fetch accepted in the same cycle.
        tbl.push_back(mk(1,0,0,0, 1,0, 0,0,0,       1,0,0,0,0));
        mark_s4a = tbl.size() - 1;
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,1,1,0));
        mark_s4b = tbl.size() - 1;
        // Write in RUN, stray ld_done, then reads and stray ld_start during LOAD.
        tbl.push_back(mk(0,0,0,0, 0,0, 1,5,32'hDEAD_BEEF, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1, 0,0,0,       0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0, 0,0,0,       0,0,0,0,0));
        tbl.push_back(mk(1,1,1,2, 0,0, 0,0,0,       0,0,1,0,0));
        tbl.push_back(mk(1,1,1,2, 1,0, 0,0,0,       0,0,1,1,0));
        tbl.push_back(mk(1,3,0,0, 0,1, 0,0,0,       0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,       0,0,0,0,0));

        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i]);
`ifdef RV32_IMEM_ARB_STATS_EN
            if (i == mark_s3) begin
                chk32("stat_fetch_after_contention", stat_fetch_grants, 32'd2);
                chk32("stat_dbg_after_contention",   stat_dbg_grants,   32'd2);
                chk32("stat_cont_after_contention",  stat_contention,   32'd4);
            end
            if (i == mark_s4a) begin
                chk32("stat_fetch_cleared", stat_fetch_grants, 32'd0);
                chk32("stat_dbg_cleared",   stat_dbg_grants,   32'd0);
                chk32("stat_cont_cleared",  stat_contention,   32'd0);
            end
`endif
            if (i == mark_s4b) begin
                for (int a = 0; a < 108; a++)
                    cycle(stim(0,0,0,0, 0,(a==107), 1,a, 32'(a) ^ 32'hA5A5_A5A5));
                for (int a = 0; a < 108; a++)
                    cycle(stim(0,0,1,a, 0,0, 0,0,0));
                cycle(stim(0,0,0,0, 0,0, 0,0,0));
            end
        end

        // Randomized traffic; reads stay inside the region written above.
        for (int n = 0; n < 400; n++) begin
            cycle(stim($urandom_range(1,0) == 1, $urandom_range(107,0),
                       $urandom_range(1,0) == 1, $urandom_range(107,0),
                       $urandom_range(29,0) == 0, $urandom_range(7,0) == 0,
                       $urandom_range(1,0) == 1, $urandom_range(127,0), $urandom));
        end

        // Return to RUN, enter LOAD, then reset mid-cycle with a write pending.
        cycle(stim(0,0,0,0, 0,0, 0,0,0));
        cycle(stim(0,0,0,0, 0,1, 0,0,0));
        cycle(stim(0,0,0,0, 1,0, 0,0,0));
        cycle(stim(0,0,0,0, 0,0, 0,0,0));
        @(negedge clk);
        fetch_req_valid = 1; dbg_req_valid = 1;
        ld_wr_valid = 1; ld_wr_addr = AW'(200); ld_wr_data = 32'h1234_5678;
        #1;
        chk1("pre_rst_wren", mem_wren, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_in_load");
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        model_reset();

        // Response in flight is dropped asynchronously by reset.
        cycle(stim(1,10,0,0, 0,0, 0,0,0));
        #1;
        rst = 1'b1;
        #1;
        chk1("rsp_async_drop", fetch_rsp_valid, 1'b0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        model_reset();

        // First contention after reset goes to fetch, then debug.
        cycle(mk(1,11,1,12, 0,0, 0,0,0, 1,0,0,0,0));
        cycle(mk(1,11,1,12, 0,0, 0,0,0, 0,1,0,0,0));
        cycle(stim(0,0,0,0, 0,0, 0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
